// File: rtl/dht11_sequencer.sv
// dht11_sequencer
//   Runs one complete DHT11 read: drives the host start pulse, times the
//   sensor response and the 40 data bits against a shared 1 us tick, checks
//   the checksum and commits humidity/temperature bytes.
//
// Ports
//   clk, rst         clock (rising edge) / synchronous active-low reset
//   tick_us          one-cycle pulse per microsecond
//   start            read request, only honoured while idle
//   dq_in            raw DQ pad value (asynchronous to clk)
//   dq_oe            1 = pull DQ low, 0 = release to the pull-up
//   busy             read in progress
//   hum_int/hum_dec  humidity bytes of the last good frame
//   tmp_int/tmp_dec  temperature bytes of the last good frame
//   valid            one-cycle pulse when new bytes are committed
//   crc_err          one-cycle pulse when a frame fails its checksum
//   timeout_err      one-cycle pulse when a sensor phase overruns
//
// Handshake: start is a level sampled in IDLE; valid, crc_err and
// timeout_err are single-cycle, mutually exclusive completion strobes with
// no back-pressure. The FSM state is visible on the internal signal 'state'.
module dht11_sequencer #(
  parameter int START_LOW_US  = 18000,
  parameter int TIMEOUT_US    = 100,
  parameter int BIT_THRESH_US = 40,
  parameter int CNT_W         = 15
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick_us,
  input  logic       start,
  input  logic       dq_in,
  output logic       dq_oe,
  output logic       busy,
  output logic [7:0] hum_int,
  output logic [7:0] hum_dec,
  output logic [7:0] tmp_int,
  output logic [7:0] tmp_dec,
  output logic       valid,
  output logic       crc_err,
  output logic       timeout_err
);

  typedef enum logic [3:0] {
    S_IDLE, S_START_LOW, S_RELEASE, S_RESP_LOW, S_RESP_HIGH,
    S_BIT_LOW, S_BIT_HIGH, S_CHECK, S_ERROR
  } state_t;

  localparam logic [CNT_W-1:0] START_LAST  = CNT_W'(START_LOW_US - 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT_US);
  localparam logic [CNT_W-1:0] THRESH_CNT  = CNT_W'(BIT_THRESH_US);

  state_t           state;
  logic             dq_meta, dq_s, dq_prev;
  logic [CNT_W-1:0] cnt;
  logic [5:0]       bit_idx;
  logic [39:0]      shift;
  logic             fall, rise, phase_to;
  logic [7:0]       sum;

  assign fall     = dq_prev & ~dq_s;
  assign rise     = ~dq_prev & dq_s;
  assign phase_to = (cnt == TIMEOUT_CNT);
  // Checksum is the 8-bit wrapped sum of the four data bytes.
  assign sum      = shift[39:32] + shift[31:24] + shift[23:16] + shift[15:8];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state       <= S_IDLE;
      dq_meta     <= 1'b1;
      dq_s        <= 1'b1;
      dq_prev     <= 1'b1;
      cnt         <= '0;
      bit_idx     <= '0;
      shift       <= '0;
      dq_oe       <= 1'b0;
      busy        <= 1'b0;
      hum_int     <= '0;
      hum_dec     <= '0;
      tmp_int     <= '0;
      tmp_dec     <= '0;
      valid       <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
    end else begin
      dq_meta     <= dq_in;
      dq_s        <= dq_meta;
      dq_prev     <= dq_s;
      valid       <= 1'b0;
      crc_err     <= 1'b0;
      timeout_err <= 1'b0;
      // Free-running saturating count; every transition below clears it,
      // and that later assignment overrides this one.
      if (tick_us && (cnt != '1)) cnt <= cnt + 1'b1;

      case (state)
        S_IDLE: begin
          dq_oe <= 1'b0;
          if (start) begin
            state <= S_START_LOW;
            dq_oe <= 1'b1;
            busy  <= 1'b1;
            cnt   <= '0;
          end
        end
        S_START_LOW: begin
          if (tick_us && (cnt == START_LAST)) begin
            state <= S_RELEASE;
            dq_oe <= 1'b0;
            cnt   <= '0;
          end
        end
        // In the waiting states an edge takes priority over a timeout
        // that lands in the same cycle.
        S_RELEASE, S_RESP_HIGH: begin
          if (fall) begin
            state   <= (state == S_RELEASE) ? S_RESP_LOW : S_BIT_LOW;
            bit_idx <= '0;
            cnt     <= '0;
          end else if (phase_to) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end
        S_RESP_LOW, S_BIT_LOW: begin
          if (rise) begin
            state <= (state == S_RESP_LOW) ? S_RESP_HIGH : S_BIT_HIGH;
            cnt   <= '0;
          end else if (phase_to) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end
        S_BIT_HIGH: begin
          if (fall) begin
            // The width of the high phase encodes the bit value.
            shift <= {shift[38:0], (cnt > THRESH_CNT)};
            cnt   <= '0;
            if (bit_idx == 6'd39) begin
              state <= S_CHECK;
            end else begin
              bit_idx <= bit_idx + 6'd1;
              state   <= S_BIT_LOW;
            end
          end else if (phase_to) begin
            state       <= S_ERROR;
            timeout_err <= 1'b1;
            cnt         <= '0;
          end
        end
        S_CHECK: begin
          if (sum == shift[7:0]) begin
            hum_int <= shift[39:32];
            hum_dec <= shift[31:24];
            tmp_int <= shift[23:16];
            tmp_dec <= shift[15:8];
            valid   <= 1'b1;
          end else begin
            crc_err <= 1'b1;
          end
          state <= S_IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        S_ERROR: begin
          dq_oe <= 1'b0;
          busy  <= 1'b0;
          state <= S_IDLE;
          cnt   <= '0;
        end
        default: begin
          state <= S_IDLE;
          dq_oe <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dht11_sequencer.sv
// Testbench for dht11_sequencer: open-drain sensor model, reference model of
// the frame/checksum rules, expected-data queue and summary report.
module tb_dht11_sequencer;

  localparam int START_LOW_US = 20;
  localparam int TIMEOUT_US   = 100;

  logic       clk = 1'b0;
  logic       rst, tick_us, start, dq_in;
  logic       dq_oe, busy, valid, crc_err, timeout_err;
  logic [7:0] hum_int, hum_dec, tmp_int, tmp_dec;
  logic       sensor_rel;

  int n_vec = 0;
  int n_err = 0;
  int tick_per = 10;
  int div = 0;
  int v_n = 0, c_n = 0, t_n = 0, excl = 0, oe_bad = 0, unexp = 0;
  logic [31:0] exp_q[$];
  logic [31:0] last_good = '0;

  dht11_sequencer #(
    .START_LOW_US (START_LOW_US),
    .TIMEOUT_US   (TIMEOUT_US),
    .BIT_THRESH_US(40),
    .CNT_W        (15)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .tick_us    (tick_us),
    .start      (start),
    .dq_in      (dq_in),
    .dq_oe      (dq_oe),
    .busy       (busy),
    .hum_int    (hum_int),
    .hum_dec    (hum_dec),
    .tmp_int    (tmp_int),
    .tmp_dec    (tmp_dec),
    .valid      (valid),
    .crc_err    (crc_err),
    .timeout_err(timeout_err)
  );

  // ---------------- clock / reset / tick ----------------
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (div >= tick_per - 1) begin
      tick_us = 1'b1;
      div = 0;
    end else begin
      tick_us = 1'b0;
      div = div + 1;
    end
  end

  // Open-drain pad: host pulls low, otherwise the sensor decides.
  assign dq_in = dq_oe ? 1'b0 : sensor_rel;

  // ---------------- checking ----------------
  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_rng(input string tag, input int obs, input int lo, input int hi);
    n_vec++;
    assert (obs >= lo && obs <= hi) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  // Monitor: counts strobes and scores committed bytes against exp_q.
  always @(negedge clk) begin
    if (rst === 1'b1) begin
      if (valid === 1'b1) begin
        v_n++;
        if (exp_q.size() == 0) unexp++;
        else chk("valid_bytes", {hum_int, hum_dec, tmp_int, tmp_dec}, exp_q.pop_front());
      end
      if (crc_err === 1'b1) c_n++;
      if (timeout_err === 1'b1) begin
        t_n++;
        if (dq_oe !== 1'b0) oe_bad++;
      end
      if ((int'(valid === 1'b1) + int'(crc_err === 1'b1) + int'(timeout_err === 1'b1)) > 1) excl++;
    end
  end

  // ---------------- reference model ----------------
  // Frame bytes in wire order: hum_int, hum_dec, tmp_int, tmp_dec, checksum.
  task automatic model_frame(input logic [39:0] f, output bit good);
    int b[5];
    for (int k = 0; k < 5; k++) b[k] = int'(f[39 - 8*k -: 8]);
    good = (((b[0] + b[1] + b[2] + b[3]) % 256) == b[4]);
    if (good) begin
      exp_q.push_back(f[39:8]);
      last_good = f[39:8];
    end
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, "_hum_int"}, hum_int, last_good[31:24]);
    chk({tag, "_hum_dec"}, hum_dec, last_good[23:16]);
    chk({tag, "_tmp_int"}, tmp_int, last_good[15:8]);
    chk({tag, "_tmp_dec"}, tmp_dec, last_good[7:0]);
  endtask

  // ---------------- driver tasks ----------------
  task automatic us_wait(input int us);
    repeat (us * tick_per) @(negedge clk);
  endtask

  // Pulse start and follow the host start pulse until DQ is released.
  task automatic start_and_release(input string tag);
    int hi, bl;
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    hi = 0;
    bl = 0;
    while (dq_oe === 1'b1 && hi < 40000) begin
      hi++;
      if (busy !== 1'b1) bl++;
      @(negedge clk);
    end
    chk_rng({tag, "_start_low"}, hi, (START_LOW_US - 1) * tick_per + 1, START_LOW_US * tick_per);
    chk({tag, "_busy_in_start"}, bl, 0);
    chk({tag, "_busy_at_release"}, busy, 1);
  endtask

  // Sensor side: response 80/80 us, then nbits data bits, then a final low
  // that terminates the last bit before the line is released for good.
  task automatic sensor_frame(input logic [39:0] f, input int nbits, input bit rnd, input bit poke);
    int t;
    us_wait(20);
    sensor_rel = 1'b0;
    us_wait(80);
    sensor_rel = 1'b1;
    us_wait(80);
    for (int i = 0; i < nbits; i++) begin
      sensor_rel = 1'b0;
      if (poke && i == 10) begin
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
      end
      us_wait(6);
      sensor_rel = 1'b1;
      if (f[39 - i]) t = rnd ? int'($urandom_range(60, 75)) : 70;
      else           t = rnd ? int'($urandom_range(20, 30)) : 27;
      us_wait(t);
    end
    sensor_rel = 1'b0;
    us_wait(6);
    sensor_rel = 1'b1;
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 5000) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_returns_idle"}, busy, 0);
    repeat (2) @(negedge clk);
  endtask

  task automatic run_read(input string tag, input logic [39:0] f, input int nbits,
                          input bit rnd, input bit poke);
    int v0, c0, t0;
    bit good;
    v0 = v_n;
    c0 = c_n;
    t0 = t_n;
    good = 1'b0;
    if (nbits == 40) model_frame(f, good);
    start_and_release(tag);
    sensor_frame(f, nbits, rnd, poke);
    wait_idle(tag);
    chk({tag, "_valid_pulses"}, v_n - v0, (nbits == 40 && good) ? 1 : 0);
    chk({tag, "_crc_pulses"}, c_n - c0, (nbits == 40 && !good) ? 1 : 0);
    chk({tag, "_timeout_pulses"}, t_n - t0, (nbits < 40) ? 1 : 0);
    chk({tag, "_dq_released"}, dq_oe, 0);
    check_outputs(tag);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int d, t0;
    logic [7:0] b[4];
    logic [7:0] cs;
    rst = 1'b0;
    start = 1'b0;
    sensor_rel = 1'b1;
    repeat (5) @(negedge clk);

    chk("rst_dq_oe", dq_oe, 0);
    chk("rst_busy", busy, 0);
    chk("rst_valid", valid, 0);
    chk("rst_crc_err", crc_err, 0);
    chk("rst_timeout_err", timeout_err, 0);
    check_outputs("rst");
    rst = 1'b1;
    repeat (3) @(negedge clk);

    // Good frame, then the same frame with a bad checksum while start is
    // poked mid-frame.
    run_read("good", 40'h35_00_18_00_4D, 40, 1'b0, 1'b0);
    run_read("badcrc", 40'h35_00_18_00_4E, 40, 1'b0, 1'b1);

    // Line stuck high after bit 17.
    run_read("stuck", 40'h35_00_18_00_4D, 18, 1'b0, 1'b0);

    // Sensor never answers: timeout 100 ticks after release.
    t0 = t_n;
    start_and_release("noans");
    d = 1;
    while (timeout_err !== 1'b1 && d < 3000) begin
      @(negedge clk);
      d++;
    end
    chk("noans_timeout_latency", d, TIMEOUT_US * tick_per + 2);
    chk("noans_dq_oe_at_err", dq_oe, 0);
    wait_idle("noans");
    chk("noans_timeout_pulses", t_n - t0, 1);
    check_outputs("noans");

    // Next start accepted, then reset in the middle of the start pulse.
    @(negedge clk) start = 1'b1;
    @(negedge clk) start = 1'b0;
    chk("restart_dq_oe", dq_oe, 1);
    chk("restart_busy", busy, 1);
    repeat (30) @(negedge clk);
    t0 = t_n;
    rst = 1'b0;
    @(negedge clk);
    last_good = '0;
    chk("midrst_dq_oe", dq_oe, 0);
    chk("midrst_busy", busy, 0);
    check_outputs("midrst");
    rst = 1'b1;
    repeat (20) @(negedge clk);
    chk("midrst_no_err", t_n - t0, 0);
    chk("midrst_idle_oe", dq_oe, 0);

    // Random frames on a faster tick with jittered bit widths.
    tick_per = 4;
    for (int r = 0; r < 2; r++) begin
      for (int k = 0; k < 4; k++) b[k] = 8'($urandom_range(0, 255));
      cs = b[0] + b[1] + b[2] + b[3];
      if (r == 1 && $urandom_range(0, 1) == 1) cs = cs ^ (8'd1 << $urandom_range(0, 7));
      run_read($sformatf("rand%0d", r), {b[0], b[1], b[2], b[3], cs}, 40, 1'b1, 1'b0);
    end

    chk("pulses_exclusive", excl, 0);
    chk("timeout_with_dq_oe", oe_bad, 0);
    chk("unexpected_valid", unexp, 0);
    chk("exp_q_drained", exp_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/dht11_sequencer.md
Name: dht11_sequencer

Overview:
- Transaction controller for the DHT11 single-wire sensor; sequences one complete read.
- Drives the host start pulse, then times the sensor response and all 40 data bits from a shared 1 µs tick, using the same µs timing base as the delay block.
- Checks the checksum and presents humidity/temperature bytes to the display/UART logic.
- Sits between the board-level open-drain DQ pad and the application layer.

Parameters:
- START_LOW_US, 18000: host start-pulse low time in µs.
- TIMEOUT_US, 100: maximum µs allowed in any sensor-driven phase before abort.
- BIT_THRESH_US, 40: high-phase length (µs) strictly above which a bit is decoded as 1.
- CNT_W, 15: width of the µs phase counter; must hold START_LOW_US.

Ports:
- clk, input, 1: system clock; all logic on rising edge.
- rst, input, 1: synchronous, active-low reset.
- tick_us, input, 1: one-cycle pulse once per µs.
- start, input, 1: request a read; sampled only in IDLE.
- dq_in, input, 1: DQ pad value (asynchronous).
- dq_oe, output, 1: 1 = drive DQ low; 0 = release (pull-up).
- busy, output, 1: high from the cycle after start is accepted until return to IDLE.
- hum_int, output, 8: humidity integer byte.
- hum_dec, output, 8: humidity decimal byte.
- tmp_int, output, 8: temperature integer byte.
- tmp_dec, output, 8: temperature decimal byte.
- valid, output, 1: one-cycle pulse when new data bytes are committed.
- crc_err, output, 1: one-cycle pulse on checksum mismatch.
- timeout_err, output, 1: one-cycle pulse on phase timeout.

Behaviour:
- Reset (rst=0 at clk edge):
  - state=IDLE; dq_oe=0, busy=0, valid/crc_err/timeout_err=0.
  - All data bytes 0; phase counter 0; bit index 0; shift register 0.
  - Synchronizer flops = 1.
  - Reset mid-transaction aborts immediately and releases DQ the next cycle; no error pulse.
- dq_in passes through a 2-flop synchronizer (dq_s). Edges are detected on dq_s against its previous value, so edge latency is 3 clk from the pad.
- Phase counter:
  - Cleared on every state transition.
  - Increments on tick_us; saturates at all-ones.
- In any waiting state, cnt==TIMEOUT_US → ERROR.
- States:
  - IDLE: dq_oe=0. start=1 → START_LOW (dq_oe=1, busy=1 next cycle). start in other states is ignored.
  - START_LOW: dq_oe=1. On tick_us with cnt==START_LOW_US-1 → RELEASE; dq_oe=0 that same edge.
  - RELEASE: wait dq_s fall → RESP_LOW; timeout → ERROR.
  - RESP_LOW: wait rise → RESP_HIGH; timeout → ERROR.
  - RESP_HIGH: wait fall → BIT_LOW; bit index=0.
  - BIT_LOW: wait rise → BIT_HIGH; timeout → ERROR.
  - BIT_HIGH: wait fall.
    - Decoded bit = (cnt > BIT_THRESH_US), shifted into a 40-bit register MSB-first.
    - If bit index==39 → CHECK, else index+1 → BIT_LOW.
    - Timeout → ERROR (covers a stuck-high line).
  - CHECK: one cycle. Compute byte4+byte3+byte2+byte1 mod 256 (8-bit wrap) and compare with byte0.
    - Match: latch bytes into the outputs; valid=1 for one cycle.
    - Mismatch: outputs keep their old values; crc_err=1 for one cycle.
    - Either way → IDLE.
  - ERROR: one cycle; timeout_err=1, dq_oe=0 → IDLE.
- busy drops in the cycle the FSM re-enters IDLE.
- valid, crc_err and timeout_err are mutually exclusive.
- Byte order as received: hum_int, hum_dec, tmp_int, tmp_dec, checksum.
- A fall and a timeout in the same cycle: the edge wins.

Test Plan:
- Bench parameters START_LOW_US=20, TIMEOUT_US=100, tick_us every 10 clk. Pulse start → dq_oe high for exactly 20 ticks, then released; busy=1 throughout.
- Sensor model sends response 80/80 µs, then data 0x35,0x00,0x18,0x00,0x4D with 0-bits high 27 µs and 1-bits high 70 µs → valid pulse once; hum_int=0x35, tmp_int=0x18; crc_err=0.
- Same frame with checksum 0x4E → crc_err pulse; outputs retain the previous values; valid stays 0.
- Sensor never answers after release → timeout_err pulse at cnt==100; dq_oe=0; busy falls; the next start is accepted.
- Line held high after bit 17 → timeout_err; FSM returns to IDLE.
- Assert rst=0 during START_LOW → next cycle dq_oe=0, busy=0, all outputs 0. Also pulse start while busy → no restart and no effect on the frame in flight.
